// File: rtl/wave_capture_buf.sv
// Double-banked trigger capture: kept ADC samples fill the hidden bank, and the banks swap on frame_start once that bank is full.
// Read latency is 1 pclk from x to sample_8b; there is no backpressure, and kept samples are dropped while a full trace waits to be shown.
module wave_capture_buf #(
    parameter int H_VALID    = 800,
    parameter int DECIM      = 1,
    parameter int TRIG_LEVEL = 128,
    parameter int TIMEOUT    = 4096
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        adc_valid,
    input  logic [7:0]  adc_data,
    input  logic        frame_start,
    input  logic [10:0] x,
    output logic [7:0]  sample_8b,
    output logic        cap_busy,
    output logic        swap_pulse
);

    localparam int AW = (H_VALID > 1) ? $clog2(H_VALID) : 1;
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0]    TL     = 8'(TRIG_LEVEL);
    localparam logic [AW-1:0] LAST_A = AW'(H_VALID - 1);
    localparam logic [10:0]   LAST_X = 11'(H_VALID - 1);
    localparam logic [DW-1:0] LAST_D = DW'(DECIM - 1);
    localparam logic [TW-1:0] LAST_T = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {ARM, WAIT_TRIG, CAPTURE, FULL} state_t;

    state_t          r_state;
    logic            r_disp_bank;
    logic [AW-1:0]   r_wr_addr;
    logic [DW-1:0]   r_dec_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [7:0]      r_prev;
    logic [7:0]      r_mem [0:1][0:H_VALID-1];

    logic            w_kept;
    logic            w_trig;
    logic            w_auto;
    logic            w_fire;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [AW-1:0]   w_rd_addr;

    assign w_kept    = adc_valid && (r_dec_cnt == '0);
    assign w_trig    = (r_prev < TL) && (adc_data >= TL);
    assign w_auto    = (TIMEOUT != 0) && (r_to_cnt == LAST_T);
    assign w_fire    = w_kept && (r_state == WAIT_TRIG) && (w_trig || w_auto);
    assign w_wr_en   = w_fire || (w_kept && (r_state == CAPTURE));
    assign w_wr_addr = w_fire ? '0 : r_wr_addr;
    assign w_rd_addr = (x > LAST_X) ? LAST_A : x[AW-1:0];
    assign cap_busy  = (r_state != FULL);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARM;
            r_disp_bank <= 1'b0;
            r_wr_addr   <= '0;
            r_dec_cnt   <= '0;
            r_to_cnt    <= '0;
            r_prev      <= 8'd0;
            sample_8b   <= 8'd0;
            swap_pulse  <= 1'b0;
        end else begin
            swap_pulse <= 1'b0;
            sample_8b  <= r_mem[r_disp_bank][w_rd_addr];
            if (adc_valid)
                r_dec_cnt <= (r_dec_cnt == LAST_D) ? '0 : r_dec_cnt + 1'b1;
            case (r_state)
                ARM: begin
                    if (w_kept) begin
                        r_prev   <= adc_data;
                        r_to_cnt <= '0;
                        r_state  <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (w_kept) begin
                        r_prev <= adc_data;
                        if (w_trig || w_auto) begin
                            r_to_cnt  <= '0;
                            r_wr_addr <= AW'(1);
                            r_state   <= (H_VALID == 1) ? FULL : CAPTURE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (w_kept) begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                        if (r_wr_addr == LAST_A)
                            r_state <= FULL;
                    end
                end
                FULL: begin
                    // Only a frame boundary seen here may expose the new trace.
                    if (frame_start) begin
                        r_disp_bank <= ~r_disp_bank;
                        swap_pulse  <= 1'b1;
                        r_wr_addr   <= '0;
                        r_state     <= ARM;
                    end
                end
                default: r_state <= ARM;
            endcase
        end
    end

    // Storage is deliberately left out of reset; only the hidden bank is written.
    always_ff @(posedge pclk) begin
        if (w_wr_en)
            r_mem[~r_disp_bank][w_wr_addr] <= adc_data;
    end

endmodule

// File: tb/tb_wave_capture_buf.sv
module tb_wave_capture_buf;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        adc_valid;
    logic [7:0]  adc_data;
    logic        frame_start;
    logic [10:0] x;
    logic [7:0]  sample_8b, sample3;
    logic        cap_busy, busy3;
    logic        swap_pulse, swap3;

    int n_checks = 0;
    int n_fail   = 0;
    int n_swap   = 0;
    int n_swap3  = 0;
    logic [7:0] exp_q [$];

    always #5 pclk = ~pclk;

    wave_capture_buf #(.H_VALID(8), .DECIM(1), .TRIG_LEVEL(128), .TIMEOUT(16)) dut (
        .pclk(pclk), .rst_n(rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
        .frame_start(frame_start), .x(x), .sample_8b(sample_8b),
        .cap_busy(cap_busy), .swap_pulse(swap_pulse));

    wave_capture_buf #(.H_VALID(8), .DECIM(3), .TRIG_LEVEL(128), .TIMEOUT(0)) dut3 (
        .pclk(pclk), .rst_n(rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
        .frame_start(frame_start), .x(x), .sample_8b(sample3),
        .cap_busy(busy3), .swap_pulse(swap3));

    // Called at a falling edge; returns at the next falling edge with outputs settled.
    task automatic step(input logic v, input logic [7:0] d, input logic fs);
        adc_valid   = v;
        adc_data    = d;
        frame_start = fs;
        @(negedge pclk);
        if (swap_pulse) n_swap++;
        if (swap3) n_swap3++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        adc_valid = 1'b0;
        frame_start = 1'b0;
        adc_data = 8'd0;
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        n_swap = 0;
        n_swap3 = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        adc_valid = 1'b0;
        adc_data = 8'd0;
        frame_start = 1'b0;
        x = 11'd0;
        @(negedge pclk);
        @(negedge pclk);
        n_checks++;
        if (sample_8b !== 8'd0 || cap_busy !== 1'b1 || swap_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: sample=%0d busy=%b swap=%b, required 0 1 0", sample_8b, cap_busy, swap_pulse);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        int seq [10];
        logic [10:0] xs [11];
        logic [7:0] e;
        seq = '{100, 120, 130, 131, 132, 133, 134, 135, 136, 137};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(seq[i]), 1'b0);
            n_checks++;
            if (cap_busy !== (i < 9)) begin
                n_fail++;
                $display("FAIL normal_busy[%0d]: got %b required %b", i, cap_busy, (i < 9));
            end
        end
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        n_checks++;
        if (swap_pulse !== 1'b1 || cap_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_swap: swap=%b busy=%b required 1 1", swap_pulse, cap_busy);
        end
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        n_checks++;
        if (n_swap != 1 || swap_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_swap_once: swaps=%0d pulse=%b required 1 0", n_swap, swap_pulse);
        end
        xs = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 900, 2047};
        for (int i = 0; i < 11; i++) begin
            x = xs[i];
            exp_q.push_back((i < 8) ? 8'(130 + i) : 8'd137);
            @(negedge pclk);
            e = exp_q.pop_front();
            n_checks++;
            if (sample_8b !== e) begin
                n_fail++;
                $display("FAIL normal_read x=%0d: got %0d required %0d", xs[i], sample_8b, e);
            end
        end
    endtask

    task automatic test_auto_trigger();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 8'd50, 1'b0);
            if (i >= 22) begin
                n_checks++;
                if (cap_busy !== (i < 23)) begin
                    n_fail++;
                    $display("FAIL auto_busy[%0d]: got %b required %b", i, cap_busy, (i < 23));
                end
            end
        end
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        n_checks++;
        if (n_swap != 1) begin
            n_fail++;
            $display("FAIL auto_swap: swaps=%0d required 1", n_swap);
        end
        for (int i = 0; i < 8; i++) begin
            x = 11'(i);
            exp_q.push_back(8'd50);
            @(negedge pclk);
            e = exp_q.pop_front();
            n_checks++;
            if (sample_8b !== e) begin
                n_fail++;
                $display("FAIL auto_read x=%0d: got %0d required %0d", i, sample_8b, e);
            end
        end
    endtask

    task automatic test_swap_gating();
        int seq [9];
        logic fs [9];
        logic [7:0] e;
        do_reset();
        seq = '{100, 130, 140, 141, 142, 143, 144, 145, 146};
        fs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) step(1'b1, 8'(seq[i]), fs[i]);
        n_checks++;
        if (cap_busy !== 1'b0 || n_swap != 0) begin
            n_fail++;
            $display("FAIL gate_final: busy=%b swaps=%0d required 0 0", cap_busy, n_swap);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0);
        n_checks++;
        if (cap_busy !== 1'b0 || n_swap != 0) begin
            n_fail++;
            $display("FAIL gate_hold: busy=%b swaps=%0d required 0 0", cap_busy, n_swap);
        end
        step(1'b0, 8'd0, 1'b1);
        n_checks++;
        if (n_swap != 1 || cap_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gate_swap: swaps=%0d busy=%b required 1 1", n_swap, cap_busy);
        end
        step(1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            x = 11'(i);
            exp_q.push_back(8'(seq[i + 1]));
            @(negedge pclk);
            e = exp_q.pop_front();
            n_checks++;
            if (sample_8b !== e) begin
                n_fail++;
                $display("FAIL gate_read x=%0d: got %0d required %0d", i, sample_8b, e);
            end
        end
    endtask

    task automatic test_decimation();
        logic [7:0] e;
        do_reset();
        for (int d = 0; d < 156; d++) begin
            step(1'b1, 8'(d), 1'b0);
            if (d == 149 || d == 150) begin
                n_checks++;
                if (busy3 !== (d < 150)) begin
                    n_fail++;
                    $display("FAIL decim_busy d=%0d: got %b required %b", d, busy3, (d < 150));
                end
            end
        end
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        n_checks++;
        if (n_swap3 != 1) begin
            n_fail++;
            $display("FAIL decim_swap: swaps=%0d required 1", n_swap3);
        end
        for (int i = 0; i < 8; i++) begin
            x = 11'(i);
            exp_q.push_back(8'(129 + 3 * i));
            @(negedge pclk);
            e = exp_q.pop_front();
            n_checks++;
            if (sample3 !== e) begin
                n_fail++;
                $display("FAIL decim_read x=%0d: got %0d required %0d", i, sample3, e);
            end
        end
    endtask

    task automatic test_reset_mid_capture();
        logic [7:0] e;
        do_reset();
        step(1'b1, 8'd100, 1'b0);
        step(1'b1, 8'd130, 1'b0);
        step(1'b1, 8'd131, 1'b0);
        step(1'b1, 8'd132, 1'b0);
        rst_n = 1'b0;
        adc_valid = 1'b0;
        #1;
        n_checks++;
        if (sample_8b !== 8'd0 || cap_busy !== 1'b1 || swap_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: sample=%0d busy=%b swap=%b required 0 1 0", sample_8b, cap_busy, swap_pulse);
        end
        @(negedge pclk);
        rst_n = 1'b1;
        n_swap = 0;
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        n_checks++;
        if (n_swap != 0 || cap_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_noswap: swaps=%0d busy=%b required 0 1", n_swap, cap_busy);
        end
        step(1'b1, 8'd100, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(200 + i), 1'b0);
        n_checks++;
        if (cap_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_restart: busy=%b required 0", cap_busy);
        end
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        n_checks++;
        if (n_swap != 1) begin
            n_fail++;
            $display("FAIL midreset_swap: swaps=%0d required 1", n_swap);
        end
        for (int i = 0; i < 8; i++) begin
            x = 11'(i);
            exp_q.push_back(8'(200 + i));
            @(negedge pclk);
            e = exp_q.pop_front();
            n_checks++;
            if (sample_8b !== e) begin
                n_fail++;
                $display("FAIL midreset_read x=%0d: got %0d required %0d", i, sample_8b, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_auto_trigger();
        test_swap_gating();
        test_decimation();
        test_reset_mid_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
